// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path: default widths,
// requester count/indices and the fixed-priority pick helper.
package rf_pkg;
  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int NREQ       = 3;
  localparam int REQ_LOAD   = 0;
  localparam int REQ_MULDIV = 1;
  localparam int REQ_ALU    = 2;

  // Isolates the lowest set bit, so index 0 has highest priority.
  function automatic logic [NREQ-1:0] pick_lowest(input logic [NREQ-1:0] v);
    return v & (~v + NREQ'(1));
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register (r0 excluded),
// raising stall when a source or the issuing destination is still in flight.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] Reg1,
  input  logic [ADDR_W-1:0] Reg2,
  output logic              stall
);
  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] pending;

  // A new issue to a register outranks a write-back retiring it in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int j = 1; j < NREG; j++) begin
        if (iss_valid && iss_dest == ADDR_W'(j))
          pending[j] <= 1'b1;
        else if (wr_en && wr_addr == ADDR_W'(j))
          pending[j] <= 1'b0;
      end
    end
  end

  assign stall = pending[Reg1] | pending[Reg2] | (iss_valid & pending[iss_dest]);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: grants one of LOAD/MULDIV/ALU per cycle with starvation
// promotion, registers the winning write onto the register-file port.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   RegWre,
  output logic [ADDR_W-1:0]      WriteReg,
  output logic [DATA_W-1:0]      WriteData,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_dest,
  input  logic [ADDR_W-1:0]      Reg1,
  input  logic [ADDR_W-1:0]      Reg2,
  output logic                   stall
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [NREQ-1:0][CNT_W-1:0] wait_cnt;
  logic [NREQ-1:0]            starved;
  logic [NREQ-1:0]            gnt;
  logic                       xfer;
  logic [ADDR_W-1:0]          sel_addr;
  logic [DATA_W-1:0]          sel_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_starve
    assign starved[i] = req_valid[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || gnt[i])
          wait_cnt[i] <= '0;
        else if (!starved[i])
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Any starved requester preempts base priority; the same index order breaks ties.
  always_comb begin
    gnt = '0;
    if (!rst)
      gnt = (|starved) ? pick_lowest(starved) : pick_lowest(req_valid);
  end

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to r0 still consume the grant but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWre <= xfer && (sel_addr != '0);
      if (xfer) begin
        WriteReg  <= sel_addr;
        WriteData <= sel_data;
      end
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .wr_en     (RegWre),
    .wr_addr   (WriteReg),
    .Reg1      (Reg1),
    .Reg2      (Reg2),
    .stall     (stall)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench for rf_wb_arbiter with a queue-based scoreboard
// and a reference model of grant, wait, pending and stall rules.
module tb_rf_wb_arbiter;
  import rf_pkg::*;
  localparam int DW = 32, AW = 5, SL = 4, NR = NREQ, NREG = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              RegWre;
  logic [AW-1:0]     WriteReg;
  logic [DW-1:0]     WriteData;
  logic              iss_valid = 1'b0;
  logic [AW-1:0]     iss_dest = '0, Reg1 = '0, Reg2 = '0;
  logic              stall;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .RegWre(RegWre),
    .WriteReg(WriteReg), .WriteData(WriteData), .iss_valid(iss_valid),
    .iss_dest(iss_dest), .Reg1(Reg1), .Reg2(Reg2), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  // Reference model state
  int            wait_cycles[NR];
  bit            pend[NREG];
  bit            m_wre = 1'b0;
  logic [AW-1:0] m_wreg = '0;
  wr_t           exp_q[$];
  logic [NR-1:0] last_rdy = '0;

  always @(negedge clk) begin : model
    int win;
    logic [NR-1:0] eg;
    bit st;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (rst) begin
      foreach (wait_cycles[i]) wait_cycles[i] = 0;
      foreach (pend[i]) pend[i] = 1'b0;
      m_wre = 1'b0;
      exp_q.delete();
      last_rdy = '0;
      chk("ready_in_reset", 64'(req_ready), 64'(0));
      chk("wre_in_reset", 64'(RegWre), 64'(0));
    end else begin
      win = -1;
      for (int i = 0; i < NR; i++) if (win < 0 && req_valid[i] && wait_cycles[i] >= SL) win = i;
      for (int i = 0; i < NR; i++) if (win < 0 && req_valid[i]) win = i;
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(eg));
      chk("RegWre", 64'(RegWre), 64'(m_wre));
      st = pend[Reg1] || pend[Reg2] || (iss_valid && pend[iss_dest]);
      chk("stall", 64'(stall), 64'(st));
      last_rdy = req_ready;
      if (m_wre) pend[m_wreg] = 1'b0;
      if (iss_valid && iss_dest != 0) pend[iss_dest] = 1'b1;
      m_wre = 1'b0;
      if (win >= 0) begin
        a = req_addr[win*AW +: AW];
        d = req_data[win*DW +: DW];
        if (a != 0) begin
          m_wre  = 1'b1;
          m_wreg = a;
          exp_q.push_back('{a, d});
        end
      end
      for (int i = 0; i < NR; i++)
        wait_cycles[i] = (!req_valid[i] || i == win) ? 0 :
                         (wait_cycles[i] < SL ? wait_cycles[i] + 1 : SL);
    end
  end

  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst && RegWre === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected none at %0t", WriteReg, WriteData, $time);
      end else begin
        e = exp_q.pop_front();
        chk("WriteReg", 64'(WriteReg), 64'(e.a));
        chk("WriteData", 64'(WriteData), 64'(e.d));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle and withdraw any request that was granted.
  task automatic step_hold();
    step();
    for (int i = 0; i < NR; i++) if (last_rdy[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    logic [AW-1:0] wa[3];
    logic [DW-1:0] wd[3];
    logic [NR-1:0] exp_gnt[6];
    repeat (2) step();
    chk("rst_RegWre", 64'(RegWre), 64'(0));
    chk("rst_WriteReg", 64'(WriteReg), 64'(0));
    chk("rst_WriteData", 64'(WriteData), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    rst = 1'b0;
    step();

    // All three at once: LOAD, MULDIV, ALU drain in order.
    wa = '{5'd3, 5'd4, 5'd5};
    wd = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int i = 0; i < NR; i++) set_req(i, wa[i], wd[i]);
    for (int k = 0; k < 3; k++) begin
      step_hold();
      chk("seq_wre", 64'(RegWre), 64'(1));
      chk("seq_reg", 64'(WriteReg), 64'(wa[k]));
      chk("seq_data", 64'(WriteData), 64'(wd[k]));
    end
    step_hold();

    // LOAD and ALU held: ALU promoted on the fifth cycle.
    exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
    set_req(REQ_LOAD, 5'd1, 32'h1111);
    set_req(REQ_ALU, 5'd2, 32'h2222);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("starve_gnt", 64'(last_rdy), 64'(exp_gnt[k]));
    end
    req_valid = '0;
    step();

    // ALU to r0: granted, no write.
    set_req(REQ_ALU, 5'd0, 32'hFFFF_FFFF);
    step_hold();
    chk("r0_granted", 64'(last_rdy), 64'(3'b100));
    chk("r0_no_wre", 64'(RegWre), 64'(0));

    // Issue to r7, read it, then retire through MULDIV.
    iss_valid = 1'b1; iss_dest = 5'd7;
    step();
    iss_valid = 1'b0; Reg1 = 5'd7;
    #1 chk("pend7_stall", 64'(stall), 64'(1));
    set_req(REQ_MULDIV, 5'd7, 32'h7777);
    step_hold();
    chk("pend7_wre_cycle", 64'(stall), 64'(1));
    step();
    chk("pend7_cleared", 64'(stall), 64'(0));

    // Issue to r9 in the cycle r9 is written: set wins.
    Reg1 = 5'd0;
    set_req(REQ_LOAD, 5'd9, 32'h9999);
    step_hold();
    iss_valid = 1'b1; iss_dest = 5'd9;
    step();
    iss_valid = 1'b0; Reg2 = 5'd9;
    #1 chk("set_wins_stall", 64'(stall), 64'(1));
    Reg2 = 5'd0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_rdy[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_dest  = AW'($urandom_range(0, 15));
      Reg1      = AW'($urandom_range(0, 15));
      Reg2      = AW'($urandom_range(0, 15));
      step();
    end
    req_valid = '0; iss_valid = 1'b0;
    step();

    // Reset mid-stream with a registered write and a pending register.
    iss_valid = 1'b1; iss_dest = 5'd12;
    step();
    iss_valid = 1'b0;
    set_req(REQ_MULDIV, 5'd20, 32'hDEAD_BEEF);
    step();
    Reg1 = 5'd12;
    #1;
    chk("pre_rst_wre", 64'(RegWre), 64'(1));
    chk("pre_rst_stall", 64'(stall), 64'(1));
    rst = 1'b1;
    #1;
    chk("async_RegWre", 64'(RegWre), 64'(0));
    chk("async_WriteReg", 64'(WriteReg), 64'(0));
    chk("async_WriteData", 64'(WriteData), 64'(0));
    chk("async_stall", 64'(stall), 64'(0));
    chk("async_ready", 64'(req_ready), 64'(0));
    step();
    rst = 1'b0;
    step_hold();
    chk("post_rst_grant", 64'(last_rdy), 64'(3'b010));
    req_valid = '0;
    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; 2**ADDR_W registers.
REQ-003 Parameter STARVE_LIMIT, default 4, wait cycles before a requester is promoted.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  3  write-back requests: bit0 LOAD, bit1 MULDIV, bit2 ALU.
REQ-008 req_addr  in  3*ADDR_W  destination register per requester, slice i for requester i.
REQ-009 req_data  in  3*DATA_W  write data per requester.
REQ-010 req_ready  out  3  one-hot-or-zero grant; transfer occurs when valid&ready.
REQ-011 RegWre  out  1  register-file write enable.
REQ-012 WriteReg  out  ADDR_W  register-file write address.
REQ-013 WriteData  out  DATA_W  register-file write data.
REQ-014 iss_valid  in  1  instruction issue; marks iss_dest pending.
REQ-015 iss_dest  in  ADDR_W  destination of issuing instruction.
REQ-016 Reg1, Reg2  in  ADDR_W each  source addresses (rs, rt) being read.
REQ-017 stall  out  1  hazard indication to issue logic.

Function
REQ-018 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high; req_ready combinational from req_valid and arbiter state.
REQ-019 Base priority SHALL be LOAD > MULDIV > ALU.
REQ-020 Each requester SHALL keep a wait counter: +1 per cycle valid and not granted, saturating at STARVE_LIMIT, cleared on grant or when valid low.
REQ-021 A requester whose counter equals STARVE_LIMIT SHALL override base priority; among several starved, lowest index wins.
REQ-022 Transfer at edge N SHALL drive RegWre=1, WriteReg, WriteData (registered) during cycle N+1 for exactly one cycle; no transfer -> RegWre=0 next cycle.
REQ-023 A transfer with address 0 SHALL be accepted (consumes the grant) but SHALL produce RegWre=0.
REQ-024 Scoreboard SHALL hold one pending bit per register 1..2**ADDR_W-1; register 0 never pending.
REQ-025 Pending bit SHALL set at the edge where iss_valid=1 and iss_dest!=0.
REQ-026 Pending bit SHALL clear at the edge ending a cycle with RegWre=1 and WriteReg equal to it.
REQ-027 Simultaneous set and clear of the same bit: set SHALL win.
REQ-028 stall SHALL be combinational: pending[Reg1] | pending[Reg2] | (iss_valid & pending[iss_dest]); address 0 never stalls.
REQ-029 Back-to-back grants SHALL be supported: one write per cycle sustained.

Reset
REQ-030 rst SHALL asynchronously force RegWre=0, WriteReg=0, WriteData=0, all wait counters 0, all pending bits 0.
REQ-031 Requests in flight at reset SHALL be lost; req_ready SHALL be 0 while rst is high; first grant possible in first cycle after release.

Structure
REQ-032 Shared package rf_pkg SHALL hold DATA_W/ADDR_W defaults, NREQ=3, and requester index constants REQ_LOAD=0, REQ_MULDIV=1, REQ_ALU=2.
REQ-033 Scoreboard (REQ-024..028) SHALL be a sub-module rf_scoreboard; arbitration and output register stay in the top.

Verification
REQ-034 All three valid, addrs 3/4/5, data A/B/C -> grants LOAD, MULDIV, ALU on consecutive cycles; RegWre writes 3=A, 4=B, 5=C in cycles N+1..N+3.
REQ-035 LOAD and ALU held valid continuously, STARVE_LIMIT=4 -> ALU granted on the 5th cycle, then LOAD resumes.
REQ-036 Single ALU request addr 0, data 0xFFFFFFFF -> req_ready=1, next cycle RegWre=0, no pending change.
REQ-037 iss_valid dest 7, next cycle Reg1=7 -> stall=1; MULDIV writes 7 -> stall=0 in cycle after RegWre cycle.
REQ-038 iss_valid dest 9 in same cycle RegWre=1 WriteReg=9 -> pending[9] remains 1, stall with Reg2=9.
REQ-039 rst asserted mid-stream with pending bits and a registered write -> RegWre, WriteReg, WriteData, stall 0 immediately, no clock edge needed.
